// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped UART transmit stage.
// Holds register offsets relative to the MMIO base, STATUS bit positions
// and the transmit FSM state encoding.
package mmio_pkg;

  // Word offsets of the two MMIO registers from the base address
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  // STATUS register field positions
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 8;

  // Transmit FSM states, one per part of the 8N1 frame
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   dout            current head entry, valid whenever empty is low
//   full, empty     occupancy flags derived from the registered count
//   count           number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[r_head];
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  // Storage array needs no reset; only entries behind the tail are ever read
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_tail] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_doPop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO stage between the core data port and data RAM.
// Writes to TXDATA queue a byte for an 8N1 UART; STATUS reports the queue.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   addr         core data address (only addr[31:2] is decoded)
//   wdata, be    store data (big-endian lanes) and byte enables
//   ram_rdata    read word from data RAM
//   rdata        read word returned to the core
//   ram_we       byte enables forwarded to data RAM (0 for MMIO hits)
//   txd          serial output, idles high
//   tx_busy      FIFO non-empty or frame in progress
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic [31:0] ram_rdata,
  output logic [31:0] rdata,
  output logic [3:0]  ram_we,
  output logic        txd,
  output logic        tx_busy
);

  import mmio_pkg::*;

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]     TX_ADDR   = MMIO_BASE + TXDATA_OFS;
  localparam logic [31:0]     ST_ADDR   = MMIO_BASE + STATUS_OFS;

  logic          w_hitTx;
  logic          w_hitSt;
  logic          w_anyBe;
  logic          w_enq;
  logic          w_pop;
  logic [7:0]    w_txByte;
  logic [7:0]    w_fifoDout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          w_baudEnd;
  logic          w_unused;

  logic          r_overflow;
  tx_state_e     r_state;
  tx_state_e     w_stateNext;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baudNext;
  logic [2:0]    r_bitIdx;
  logic [2:0]    w_bitIdxNext;
  logic [7:0]    r_shift;
  logic [7:0]    w_shiftNext;

  // Byte-offset bits play no part in register selection
  assign w_unused = &{1'b0, addr[1:0]};

  assign w_hitTx = (addr[31:2] == TX_ADDR[31:2]);
  assign w_hitSt = (addr[31:2] == ST_ADDR[31:2]);
  assign w_anyBe = |be;
  assign w_enq   = w_hitTx && w_anyBe;
  assign ram_we  = (w_hitTx || w_hitSt) ? 4'b0000 : be;
  assign tx_busy = !w_empty || (r_state != TX_IDLE);

  // be[0] is the lowest lane (wdata[7:0]), so a full-word store sends its LSB
  always_comb begin
    w_txByte = wdata[31:24];
    if (be[0]) begin
      w_txByte = wdata[7:0];
    end else if (be[1]) begin
      w_txByte = wdata[15:8];
    end else if (be[2]) begin
      w_txByte = wdata[23:16];
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_enq),
    .din   (w_txByte),
    .pop   (w_pop),
    .dout  (w_fifoDout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_status                         = '0;
    w_status[ST_BUSY_BIT]            = tx_busy;
    w_status[ST_FULL_BIT]            = w_full;
    w_status[ST_EMPTY_BIT]           = w_empty;
    w_status[ST_OVF_BIT]             = r_overflow;
    w_status[ST_COUNT_LSB +: 8]      = 8'(w_count);
  end

  always_comb begin
    if (w_hitSt) begin
      rdata = w_status;
    end else if (w_hitTx) begin
      rdata = 32'h0000_0000;
    end else begin
      rdata = ram_rdata;
    end
  end

  // Fullness uses the registered count, so a same-cycle pop cannot save a
  // byte written into a full FIFO; a STATUS write takes priority over a set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_hitSt && w_anyBe) begin
      r_overflow <= 1'b0;
    end else if (w_enq && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= TX_IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
    end
  end

  // Baud counter restarts at zero on every state or bit change
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baud;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_pop        = 1'b0;
    w_baudEnd    = (r_baud == BAUD_LAST);
    case (r_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shiftNext  = w_fifoDout;
          w_bitIdxNext = '0;
          w_baudNext   = '0;
          w_stateNext  = TX_START;
        end
      end
      TX_START: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_stateNext = TX_DATA;
        end else begin
          w_baudNext = r_baud + 1'b1;
        end
      end
      TX_DATA: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_shiftNext = {1'b0, r_shift[7:1]};
          if (r_bitIdx == 3'd7) begin
            w_stateNext = TX_STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 1'b1;
          end
        end else begin
          w_baudNext = r_baud + 1'b1;
        end
      end
      TX_STOP: begin
        if (w_baudEnd) begin
          w_baudNext  = '0;
          w_stateNext = TX_IDLE;
        end else begin
          w_baudNext = r_baud + 1'b1;
        end
      end
      default: begin
        w_stateNext = TX_IDLE;
      end
    endcase
  end

  // Decoded straight from state so an async reset forces the line high at once
  always_comb begin
    case (r_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = r_shift[0];
      default:  txd = 1'b1;
    endcase
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped I/O stage sitting directly downstream of the single-cycle core's data port. It decodes the core's data address, write data and byte enables. It forwards ordinary accesses to data RAM and captures writes to a transmit register into a byte FIFO. The FIFO drains through an 8N1 UART transmitter, and a status register is readable by `lw`, giving programs a console output path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range is ≥2.
- `FIFO_DEPTH`, 16: transmit FIFO entries; must be a power of two, 2..128.
- `MMIO_BASE`, 32'hFFFF_0000: TXDATA word address; STATUS is at `MMIO_BASE+4`.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  32  core data address (ALU result).
- `wdata`  in  32  core store data, byte lanes big-endian.
- `be`  in  4  core byte write enables; `be[3]` selects lane `wdata[31:24]` (byte offset 0), `be[0]` selects `wdata[7:0]` (offset 3).
- `ram_rdata`  in  32  data RAM read word.
- `rdata`  out  32  read word returned to the core.
- `ram_we`  out  4  byte enables to data RAM.
- `txd`  out  1  serial output; idles high.
- `tx_busy`  out  1  FIFO non-empty or frame in progress.

## Operation
- Address decode uses `addr[31:2]` only.
  - `hit_tx`: `addr[31:2]==MMIO_BASE[31:2]`.
  - `hit_st`: `addr[31:2]==(MMIO_BASE+4)[31:2]`.
- `ram_we` = `be` when neither hit is asserted, else 4'b0000.
- Reads are combinational.
  - `hit_st`: `rdata` = STATUS.
  - `hit_tx`: `rdata` = 0.
  - Otherwise `rdata` = `ram_rdata`.
- STATUS fields:
  - bit0 `tx_busy`.
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky).
  - bits[15:8] FIFO count.
  - All other bits are 0.
- Enqueue: `hit_tx` with `be!=0`. The captured byte is taken from the lowest-numbered asserted lane, so `sw` (`be`=1111) sends `wdata[7:0]`.
- Enqueue when count==`FIFO_DEPTH`: the byte is dropped and overflow is set. A pop in the same cycle does not rescue it; fullness is judged on the registered count.
- Any write with `hit_st` and `be!=0` clears overflow. If overflow is set and cleared in the same cycle, the clear wins.
- Simultaneous enqueue and pop: both take effect and count is unchanged.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: shift out LSB first, 8 bits of `CLKS_PER_BIT` cycles each, then go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- The baud counter runs 0..`CLKS_PER_BIT`-1 and reloads on every state or bit change.

## Timing
- Reset values, applied immediately on `rst` assertion, including mid-frame:
  - FIFO empty, count 0, overflow 0.
  - FSM IDLE, `txd`=1, `tx_busy`=0.
  - Head and tail pointers 0.
- A reset that lands mid-frame truncates the frame; `txd` goes high without waiting for the next clock.
- Enqueue write at edge N (FIFO previously empty, FSM IDLE):
  - count=1 and `tx_busy`=1 after edge N.
  - Pop occurs at edge N+1.
  - `txd` falls after edge N+1.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles of non-IDLE state.
- Back-to-back frames are separated by exactly one IDLE cycle, giving a period of 10·`CLKS_PER_BIT`+1.
- `tx_busy` deasserts on the edge that returns the FSM to IDLE with the FIFO empty.
- Count arithmetic uses width log2(`FIFO_DEPTH`)+1; pointers use log2(`FIFO_DEPTH`) bits and wrap modulo depth.

## Structure
- Package `mmio_pkg` holds:
  - TXDATA and STATUS offsets.
  - STATUS bit positions.
  - The FSM state enum (2 bits).
- Sub-module `sync_fifo` (parameter `WIDTH`, `DEPTH`): push, pop, dout (head, combinational), full, empty, count.
- Top level holds the decode, the overflow flag and the UART FSM.

## Test plan
Bench uses `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- `sw` of 32'h0000_0041 to `MMIO_BASE`:
  - `txd` falls 2 edges later.
  - Sampled bits are 0,1,0,0,0,0,0,1,0,1 (start, 8'h41 LSB-first, stop).
  - `tx_busy` drops after 40 non-IDLE cycles.
- `sb` with `be`=1000, `wdata`=32'h5A00_0000 → frame carries 8'h5A.
- RAM access: non-MMIO `sw`, `be`=1111 → `ram_we`=1111, FIFO untouched.
- RAM read: non-MMIO read → `rdata`=`ram_rdata`.
- Six back-to-back enqueues 1..6:
  - The first byte pops before the 6th write, so 5 are accepted.
  - Overflow=1; STATUS reads bit3 set; the dropped byte is 6.
  - Writing STATUS clears overflow.
  - Four queued frames follow at a 41-cycle period.
- Assert `rst` during DATA state → `txd`=1 immediately, STATUS reads 32'h0000_0004 after release.
